// File: rtl/intersection_ctrl.sv
// Two-way intersection right-of-way controller with a pedestrian walk phase and an EW vehicle sensor.
// Lamps are decoded from the state register and change in the cycle after a phase expires; ped_ack is registered.
// No backpressure: car_ew and ped_req are sampled every cycle, and a request waits in ped_pend until it is serviced.
module intersection_ctrl #(
    parameter logic [31:0] GREEN_T  = 32'd30,
    parameter logic [31:0] YELLOW_T = 32'd5,
    parameter logic [31:0] ALLRED_T = 32'd2,
    parameter logic [31:0] PED_T    = 32'd10
) (
    input  logic clk,
    input  logic rst,
    input  logic car_ew,
    input  logic ped_req,
    output logic ns_r,
    output logic ns_y,
    output logic ns_g,
    output logic ew_r,
    output logic ew_y,
    output logic ew_g,
    output logic walk,
    output logic ped_ack
);

    // A zero-length phase would never expire, so it is treated as one cycle.
    localparam logic [31:0] GREEN_D  = (GREEN_T  == 32'd0) ? 32'd1 : GREEN_T;
    localparam logic [31:0] YELLOW_D = (YELLOW_T == 32'd0) ? 32'd1 : YELLOW_T;
    localparam logic [31:0] ALLRED_D = (ALLRED_T == 32'd0) ? 32'd1 : ALLRED_T;
    localparam logic [31:0] PED_D    = (PED_T    == 32'd0) ? 32'd1 : PED_T;

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR1  = 3'd2,
        PED  = 3'd3,
        EW_G = 3'd4,
        EW_Y = 3'd5,
        AR2  = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        ped_pend_q, ped_pend_d;
    logic        ped_ack_q, ped_ack_d;
    logic [31:0] phase_len;
    logic        expired;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= NS_G;
            cnt_q      <= 32'd0;
            ped_pend_q <= 1'b0;
            ped_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ped_pend_q <= ped_pend_d;
            ped_ack_q  <= ped_ack_d;
        end
    end

    always_comb begin
        phase_len = GREEN_D;
        case (state_q)
            NS_G, EW_G: phase_len = GREEN_D;
            NS_Y, EW_Y: phase_len = YELLOW_D;
            AR1, AR2:   phase_len = ALLRED_D;
            PED:        phase_len = PED_D;
            default:    phase_len = 32'd1;
        endcase
    end

    assign expired = (cnt_q == (phase_len - 32'd1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 32'd1;
        ped_pend_d = ped_pend_q | ped_req;
        ped_ack_d  = 1'b0;
        case (state_q)
            NS_G: begin
                if (expired) begin
                    if (car_ew || ped_pend_q) begin
                        state_d = NS_Y;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end
            NS_Y: begin
                if (expired) state_d = AR1;
            end
            AR1: begin
                if (expired) begin
                    if (ped_pend_q) begin
                        state_d    = PED;
                        ped_ack_d  = 1'b1;
                        // A request arriving on the service edge is kept for the next round.
                        ped_pend_d = ped_req;
                    end else begin
                        state_d = EW_G;
                    end
                end
            end
            PED: begin
                if (expired) state_d = EW_G;
            end
            EW_G: begin
                if (expired) state_d = EW_Y;
            end
            EW_Y: begin
                if (expired) state_d = AR2;
            end
            AR2: begin
                if (expired) state_d = NS_G;
            end
            default: begin
                state_d = NS_G;
            end
        endcase
        if (state_d != state_q) cnt_d = 32'd0;
    end

    // Unused encodings fall back to all-red, which keeps both heads safe.
    always_comb begin
        ns_r = 1'b1;
        ns_y = 1'b0;
        ns_g = 1'b0;
        ew_r = 1'b1;
        ew_y = 1'b0;
        ew_g = 1'b0;
        walk = 1'b0;
        case (state_q)
            NS_G: begin
                ns_r = 1'b0;
                ns_g = 1'b1;
            end
            NS_Y: begin
                ns_r = 1'b0;
                ns_y = 1'b1;
            end
            EW_G: begin
                ew_r = 1'b0;
                ew_g = 1'b1;
            end
            EW_Y: begin
                ew_r = 1'b0;
                ew_y = 1'b1;
            end
            PED:     walk = 1'b1;
            default: walk = 1'b0;
        endcase
    end

    assign ped_ack = ped_ack_q;

endmodule

// File: doc/intersection_ctrl.md
# intersection_ctrl

Two-way intersection controller that sequences a north-south and an east-west signal head from a single timer, with a pedestrian request/acknowledge handshake and an east-west vehicle sensor. It sits above the per-head lamp drivers and is the single owner of the intersection's right-of-way. All phase durations are parameterised so benches can shrink them.

## Interface

Parameters:
- GREEN_T, 32'd30: green phase length in clk cycles (minimum length for NS green).
- YELLOW_T, 32'd5: yellow phase length in cycles.
- ALLRED_T, 32'd2: all-red clearance length in cycles.
- PED_T, 32'd10: pedestrian walk phase length in cycles.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-low.
- car_ew  input  1  EW vehicle present (level, assumed synchronous).
- ped_req  input  1  pedestrian request, pulse or level; sampled every cycle.
- ns_r, ns_y, ns_g  output  1 each  NS lamps.
- ew_r, ew_y, ew_g  output  1 each  EW lamps.
- walk  output  1  pedestrian walk lamp.
- ped_ack  output  1  one-cycle acknowledge of the serviced request.

## Operation

- States: NS_G, NS_Y, AR1 (all-red), PED, EW_G, EW_Y, AR2 (all-red).
- 32-bit phase counter `cnt`; cleared on every state transition, increments each cycle otherwise. A phase of duration D "expires" when cnt == D-1. A parameter value of 0 behaves as 1.
- Transitions:
  - NS_G -> NS_Y when expired AND (car_ew OR ped_pend); otherwise stay, cnt saturates at GREEN_T-1.
  - NS_Y -> AR1 on YELLOW_T expiry.
  - AR1 -> PED if ped_pend, else EW_G, on ALLRED_T expiry.
  - PED -> EW_G on PED_T expiry.
  - EW_G -> EW_Y on GREEN_T expiry (fixed, no extension).
  - EW_Y -> AR2 on YELLOW_T expiry.
  - AR2 -> NS_G on ALLRED_T expiry.
- ped_pend register: set by ped_req=1 on any edge; cleared on the AR1->PED edge. If ped_req=1 on that same edge, set wins (the request is serviced in the next round).
- Lamp outputs are decoded from the state register only (Moore):
  - NS_G: ns_g, ew_r.
  - NS_Y: ns_y, ew_r.
  - EW_G: ns_r, ew_g.
  - EW_Y: ns_r, ew_y.
  - AR1/AR2: ns_r, ew_r.
  - PED: ns_r, ew_r, walk.
- ped_ack: registered; 1 during the first cycle of PED only.
- Invariants, which must hold every cycle:
  - Exactly one lamp is on per head.
  - Never (ns_g|ns_y) together with (ew_g|ew_y).
  - walk=1 only in PED, and only while both heads are red.
- Reset (rst=0 at a clk edge): state=NS_G, cnt=0, ped_pend=0, ped_ack=0. After that edge: ns_g=1, ew_r=1, all other outputs 0. Reset dominates any transition and works mid-phase. Before the first reset edge, outputs are undefined.

## Timing

- Each phase lasts exactly its D cycles, except NS_G, which lasts at least GREEN_T.
- Lamp changes appear in the cycle after the expiry edge. No combinational input-to-output paths.
- With car_ew=1 held and no pedestrian request, the period is 2·(GREEN_T+YELLOW_T+ALLRED_T) cycles.
- A serviced pedestrian request adds PED_T cycles between AR1 and EW_G.
- Worst-case request-to-ack latency: GREEN_T+YELLOW_T+ALLRED_T+(full remaining cycle) cycles, for a request made just after the AR1->PED decision point.

## Test plan

Bench parameters: GREEN_T=5, YELLOW_T=2, ALLRED_T=1, PED_T=3. Cycle 0 is the first edge with rst=1.

1. Reset: hold rst=0 for 2 edges -> ns_g=1, ew_r=1, walk=0, ped_ack=0; hold the same with car_ew=0 and ped_req=0 for 50 cycles (NS rests in green).
2. car_ew=1 from cycle 0 -> NS_G cycles 0-4, NS_Y 5-6, AR1 7, EW_G 8-12, EW_Y 13-14, AR2 15, NS_G again at 16. Period 16, repeating.
3. car_ew=0, ped_req 1-cycle pulse at cycle 2 -> NS_Y 5-6, AR1 7, PED 8-10 (walk=1, ped_ack=1 at 8 only), EW_G 11-15, EW_Y 16-17, AR2 18, then NS_G rests.
4. ped_req held high continuously, car_ew=0 -> PED is entered every round; ped_ack is exactly 1 cycle per PED entry.
5. rst=0 for 1 edge while in EW_Y -> next cycle ns_g=1, ew_r=1, cnt restarts from 0; a ped_pend set before the reset is discarded.
6. Invariant checker active in all scenarios, plus 10,000 cycles of random car_ew/ped_req -> zero conflicting-green, double-lamp or stray-walk violations.
